ex_operand_stage: RTL

- ID/EX pipeline register plus operand-select/forwarding logic of the 5-stage core; sits directly upstream of the ALU and drives its op, A and B inputs.
- Latches decoded instruction fields from ID.
- Resolves RAW hazards by forwarding from MEM and WB.
- Honours stall/flush from the hazard unit; presents the store-data operand to MEM.

---
 rtl/ex_operand_stage_pkg.sv | 21 ++
 rtl/ex_operand_stage_fwd_mux.sv | 35 +++
 rtl/ex_operand_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared defines for the EX operand stage: ALU op codes and default widths.
// Operand forwarding is enabled by defining the macro EX_FORWARD_EN.
package ex_operand_stage_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Priority operand select for one source register: MEM result, then WB result,
// then the latched register-file value. Register x0 is never forwarded.
module ex_fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   value
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_we && (mem_rd != '0) && (mem_rd == rs);
    assign wb_hit  = wb_we  && (wb_rd  != '0) && (wb_rd  == rs);

    always_comb begin
        value = rs_data;
        if (mem_hit) begin
            value = mem_result;
        end else if (wb_hit) begin
            value = wb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand select feeding the ALU and store data to MEM.
// Define EX_FORWARD_EN to forward MEM/WB results (and refresh operands while stalled).
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_pc,
    input  logic              id_use_imm,
    input  logic              id_reg_we,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic [XLEN-1:0]   wb_result,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_op,
    output logic [XLEN-1:0]   ex_alu_a,
    output logic [XLEN-1:0]   ex_alu_b,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_we,
    output logic [XLEN-1:0]   ex_pc
);

    logic              valid_q;
    logic [3:0]        alu_op_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [XLEN-1:0]   imm_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic              use_pc_q;
    logic              use_imm_q;
    logic              reg_we_q;
    logic [XLEN-1:0]   fwd1;
    logic [XLEN-1:0]   fwd2;

`ifdef EX_FORWARD_EN
    ex_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd1 (
        .rs         (rs1_q),
        .rs_data    (rs1_data_q),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_result (mem_result),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .wb_result  (wb_result),
        .value      (fwd1)
    );

    ex_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd2 (
        .rs         (rs2_q),
        .rs_data    (rs2_data_q),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_result (mem_result),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .wb_result  (wb_result),
        .value      (fwd2)
    );
`else
    // Without forwarding the hazard unit stalls until the writer retires,
    // so the latched register-file values are always current.
    logic unused_fwd;
    assign unused_fwd = ^{mem_rd, mem_we, mem_result, wb_rd, wb_we, wb_result,
                          rs1_q, rs2_q};
    assign fwd1 = rs1_data_q;
    assign fwd2 = rs2_data_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            alu_op_q   <= ALU_ADD;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            use_pc_q   <= 1'b0;
            use_imm_q  <= 1'b0;
            reg_we_q   <= 1'b0;
        end else if (flush) begin
            valid_q  <= 1'b0;
            reg_we_q <= 1'b0;
        end else if (stall) begin
            // Refreshing here captures a WB value before that instruction retires.
            rs1_data_q <= fwd1;
            rs2_data_q <= fwd2;
        end else begin
            valid_q    <= id_valid;
            alu_op_q   <= id_alu_op;
            pc_q       <= id_pc;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= id_rd;
            use_pc_q   <= id_use_pc;
            use_imm_q  <= id_use_imm;
            reg_we_q   <= id_reg_we;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_alu_a      = use_pc_q  ? pc_q  : fwd1;
    assign ex_alu_b      = use_imm_q ? imm_q : fwd2;
    assign ex_store_data = fwd2;
    assign ex_rd         = rd_q;
    assign ex_reg_we     = valid_q & reg_we_q;
    assign ex_pc         = pc_q;

endmodule
